// File: rtl/ttc_dispatch_pkg.sv
// Shared definitions for the TTC interrupt dispatcher.
//   state_e      : dispatcher FSM states
//   NUM_SRC_DEF  : default number of interrupt sources
//   EVT_ID_W     : width of the event source index
package ttc_dispatch_pkg;

   localparam int NUM_SRC_DEF = 6;
   localparam int EVT_ID_W    = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CAPTURE  = 3'd1,
      ST_CLEAR    = 3'd2,
      ST_CHECK    = 3'd3,
      ST_DISPATCH = 3'd4
   } state_e;

endpackage

// File: rtl/ttc_prio_pick.sv
// Combinational lowest-set-bit picker.
//   vec_i : request vector
//   idx_o : index of the lowest set bit (0 when vec_i is zero)
//   any_o : high when any bit of vec_i is set
module ttc_prio_pick #(
   parameter int W     = 6,
   parameter int IDX_W = 3
) (
   input  logic [W-1:0]     vec_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   // Scanning from the top down lets the lowest set bit win the last assignment.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = IDX_W'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ttc_intr_dispatch_lite.sv
// Service side of the TTC interrupt collector: captures the collector status,
// drains it with a clear pulse (re-issued if blocked), then hands each pending
// source to the handler over a valid/ready channel, lowest index first.
//
// Ports
//   pclk, p_reset          : clock, synchronous active-high reset
//   interrupt, intr_status : collector interrupt level and status register
//   clear_interrupt        : one-cycle clear request to the collector
//   evt_valid/evt_id/evt_ready : dispatch channel
//   busy                   : FSM not in IDLE
//   clr_err, clr_err_ack   : sticky clear-failure flag and its acknowledge
//   stat_sel, stat_cnt     : per-source event counter read port
//
// Optional feature: define TTC_DISPATCH_STATS_EN for per-source saturating
// dispatch counters; without it stat_cnt reads 0 and stat_sel is ignored.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for the collector interrupt level
// ST_CAPTURE  | snapshot intr_status; zero status is spurious -> IDLE
// ST_CLEAR    | clear_interrupt asserted for this single cycle
// ST_CHECK    | verify snapshotted bits dropped; retry clear or flag clr_err
// ST_DISPATCH | present pending sources lowest-first until all accepted
module ttc_intr_dispatch_lite
   import ttc_dispatch_pkg::*;
#(
   parameter int NUM_SRC   = NUM_SRC_DEF,
   parameter int MAX_RETRY = 3,
   parameter int CNT_W     = 8
) (
   input  logic                pclk,
   input  logic                p_reset,
   input  logic                interrupt,
   input  logic [NUM_SRC-1:0]  intr_status,
   output logic                clear_interrupt,
   output logic                evt_valid,
   output logic [EVT_ID_W-1:0] evt_id,
   input  logic                evt_ready,
   output logic                busy,
   output logic                clr_err,
   input  logic                clr_err_ack,
   input  logic [EVT_ID_W-1:0] stat_sel,
   output logic [CNT_W-1:0]    stat_cnt
);

   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   state_e               state_q, state_d;
   logic [NUM_SRC-1:0]   snap_q, snap_d;
   logic [NUM_SRC-1:0]   pend_q, pend_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic                 clr_err_q, clr_err_d;

   logic [EVT_ID_W-1:0]  pick_idx;
   logic                 pick_any;
   logic                 accept;

   ttc_prio_pick #(
      .W     (NUM_SRC),
      .IDX_W (EVT_ID_W)
   ) u_pick (
      .vec_i (pend_q),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_ff @(posedge pclk) begin
      if (p_reset) begin
         state_q   <= ST_IDLE;
         snap_q    <= '0;
         pend_q    <= '0;
         retry_q   <= '0;
         clr_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         pend_q    <= pend_d;
         retry_q   <= retry_d;
         clr_err_q <= clr_err_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      snap_d          = snap_q;
      pend_d          = pend_q;
      retry_d         = retry_q;
      clr_err_d       = clr_err_q;
      clear_interrupt = 1'b0;
      evt_valid       = 1'b0;
      evt_id          = '0;

      // Acknowledge first so a same-cycle set below overrides it.
      if (clr_err_ack) clr_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (interrupt) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            snap_d  = intr_status;
            pend_d  = intr_status;
            retry_d = '0;
            state_d = (intr_status == '0) ? ST_IDLE : ST_CLEAR;
         end
         ST_CLEAR: begin
            clear_interrupt = 1'b1;
            state_d         = ST_CHECK;
         end
         ST_CHECK: begin
            // Only snapshotted bits matter; newly arrived bits stay in the
            // collector and are picked up on the next pass.
            if ((intr_status & snap_q) == '0) begin
               retry_d = '0;
               state_d = ST_DISPATCH;
            end else if (retry_q < RETRY_MAX) begin
               retry_d = retry_q + 1'b1;
               state_d = ST_CLEAR;
            end else begin
               clr_err_d = 1'b1;
               retry_d   = '0;
               state_d   = ST_DISPATCH;
            end
         end
         ST_DISPATCH: begin
            evt_valid = pick_any;
            evt_id    = pick_idx;
            if (!pick_any) begin
               state_d = ST_IDLE;
            end else if (evt_ready) begin
               pend_d = pend_q & ~(NUM_SRC'(1) << pick_idx);
               if (pend_d == '0) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy    = (state_q != ST_IDLE);
   assign clr_err = clr_err_q;
   assign accept  = evt_valid & evt_ready;

`ifdef TTC_DISPATCH_STATS_EN
   logic [CNT_W-1:0] cnt_q [NUM_SRC];
   logic [CNT_W-1:0] cnt_d [NUM_SRC];

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
      always_comb begin
         cnt_d[g] = cnt_q[g];
         if (accept && (pick_idx == EVT_ID_W'(g)) && (cnt_q[g] != '1)) begin
            cnt_d[g] = cnt_q[g] + 1'b1;
         end
      end

      always_ff @(posedge pclk) begin
         if (p_reset) cnt_q[g] <= '0;
         else         cnt_q[g] <= cnt_d[g];
      end
   end

   // Selects beyond NUM_SRC match no counter and read 0.
   always_comb begin
      stat_cnt = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (stat_sel == EVT_ID_W'(i)) stat_cnt = cnt_q[i];
      end
   end
`else
   logic unused_stat;
   assign unused_stat = ^{stat_sel, accept};
   assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_ttc_intr_dispatch_lite.sv
module tb_ttc_intr_dispatch_lite;

   logic       pclk = 1'b0;
   logic       p_reset = 1'b1;
   logic       interrupt;
   logic [5:0] intr_status;
   logic       clear_interrupt;
   logic       evt_valid;
   logic [2:0] evt_id;
   logic       evt_ready = 1'b0;
   logic       busy;
   logic       clr_err;
   logic       clr_err_ack = 1'b0;
   logic [2:0] stat_sel = 3'd0;
   logic [7:0] stat_cnt;

   // Collector model
   logic [5:0] coll = 6'd0;
   logic [5:0] set_mask = 6'd0;
   logic       coll_clr = 1'b0;
   logic       spur = 1'b0;
   int         blk_limit = 0;
   int         blk_cnt = 0;

   int n_checks = 0;
   int n_err = 0;

   int          w_clr, w_clr_cyc, w_evt, w_first_v, w_last_busy, w_wait, w_wait_bad, w_first_acc;
   logic [17:0] w_ids;

   typedef struct {
      logic [5:0]  status;
      int          n;
      logic [17:0] ids;
   } vec_t;

   vec_t vecs[5];

   ttc_intr_dispatch_lite dut (
      .pclk            (pclk),
      .p_reset         (p_reset),
      .interrupt       (interrupt),
      .intr_status     (intr_status),
      .clear_interrupt (clear_interrupt),
      .evt_valid       (evt_valid),
      .evt_id          (evt_id),
      .evt_ready       (evt_ready),
      .busy            (busy),
      .clr_err         (clr_err),
      .clr_err_ack     (clr_err_ack),
      .stat_sel        (stat_sel),
      .stat_cnt        (stat_cnt)
   );

   always #5 pclk = ~pclk;

   assign intr_status = coll;
   assign interrupt   = (|coll) | spur;

   always @(posedge pclk) begin
      if (coll_clr) begin
         coll    <= 6'd0;
         blk_cnt <= 0;
      end else if (clear_interrupt && blk_cnt < blk_limit) begin
         blk_cnt <= blk_cnt + 1;
         coll    <= coll | set_mask;
      end else if (clear_interrupt) begin
         coll <= set_mask;
      end else begin
         coll <= coll | set_mask;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Fires mask into the collector, then observes ncyc negedges (cycle 1 is
   // the first negedge after the collector latches the mask).
   task automatic watch(input logic [5:0] mask, input int ncyc, input int rdy_cyc,
                        input int inj_cyc, input logic [5:0] inj_mask, input bit clr_on_acc);
      logic [2:0] hold_id;
      w_clr = 0; w_clr_cyc = 0; w_evt = 0; w_first_v = 0; w_last_busy = 0;
      w_wait = 0; w_wait_bad = 0; w_first_acc = 0; w_ids = '0; hold_id = '0;
      set_mask  = mask;
      evt_ready = (rdy_cyc <= 0);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge pclk);
         set_mask  = (c == inj_cyc) ? inj_mask : 6'd0;
         coll_clr  = 1'b0;
         evt_ready = (c >= rdy_cyc);
         if (clear_interrupt) begin
            w_clr++;
            if (w_clr_cyc == 0) w_clr_cyc = c;
         end
         if (busy) w_last_busy = c;
         if (evt_valid && w_first_v == 0) begin
            w_first_v = c;
            hold_id   = evt_id;
         end
         if (evt_valid && !evt_ready) begin
            w_wait++;
            if (evt_id != hold_id) w_wait_bad++;
         end
         if (evt_valid && evt_ready) begin
            if (w_evt < 6) w_ids[3*w_evt +: 3] = evt_id;
            if (w_first_acc == 0) w_first_acc = c;
            w_evt++;
            if (clr_on_acc) coll_clr = 1'b1;
         end
      end
      coll_clr  = 1'b0;
      evt_ready = 1'b0;
   endtask

   task automatic coll_reset();
      @(negedge pclk);
      coll_clr = 1'b1;
      @(negedge pclk);
      coll_clr = 1'b0;
   endtask

   initial begin
      vecs[0] = '{6'b000101, 2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0}};
      vecs[1] = '{6'b111111, 6, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
      vecs[2] = '{6'b100000, 1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5}};
      vecs[3] = '{6'b011010, 3, {3'd0, 3'd0, 3'd0, 3'd4, 3'd3, 3'd1}};
      vecs[4] = '{6'b101001, 3, {3'd0, 3'd0, 3'd0, 3'd5, 3'd3, 3'd0}};

      // Reset
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      chk("rst_clear", int'(clear_interrupt), 0);
      chk("rst_valid", int'(evt_valid), 0);
      chk("rst_id", int'(evt_id), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_clr_err", int'(clr_err), 0);
      stat_sel = 3'd5;
      chk("rst_stat", int'(stat_cnt), 0);
      p_reset = 1'b0;
      @(negedge pclk);

`ifdef TTC_DISPATCH_STATS_EN
      for (int k = 0; k < 300; k++) watch(6'b100000, 7, 1, 0, 6'd0, 1'b0);
      stat_sel = 3'd5;
      #1 chk("stat_sat_5", int'(stat_cnt), 255);
      for (int s = 0; s < 5; s++) begin
         stat_sel = 3'(s);
         #1 chk("stat_other", int'(stat_cnt), 0);
      end
      stat_sel = 3'd6;
      #1 chk("stat_sel_oor", int'(stat_cnt), 0);
      @(negedge pclk);
`endif

      // Table-driven passes with evt_ready tied high
      foreach (vecs[v]) begin
         watch(vecs[v].status, 16, 1, 0, 6'd0, 1'b0);
         chk("tbl_n_evt", w_evt, vecs[v].n);
         for (int k = 0; k < vecs[v].n; k++)
            chk("tbl_id", int'(w_ids[3*k +: 3]), int'(vecs[v].ids[3*k +: 3]));
         chk("tbl_n_clr", w_clr, 1);
         chk("tbl_clr_cyc", w_clr_cyc, 3);
         chk("tbl_first_valid", w_first_v, 5);
         chk("tbl_busy_drop", w_last_busy, 4 + vecs[v].n);
         chk("tbl_clr_err", int'(clr_err), 0);
      end
`ifndef TTC_DISPATCH_STATS_EN
      stat_sel = 3'd0;
      #1 chk("stat_tied0", int'(stat_cnt), 0);
`endif

      // Backpressure: event held 5 cycles, accepted on the 6th
      watch(6'b010000, 16, 10, 0, 6'd0, 1'b0);
      chk("bp_first_valid", w_first_v, 5);
      chk("bp_wait", w_wait, 5);
      chk("bp_wait_stable", w_wait_bad, 0);
      chk("bp_accept_cyc", w_first_acc, 10);
      chk("bp_id", int'(w_ids[2:0]), 4);
      chk("bp_n_evt", w_evt, 1);
      chk("bp_busy_drop", w_last_busy, 10);

      // Clear ignored twice
      coll_reset();
      blk_limit = 2;
      watch(6'b000010, 20, 1, 0, 6'd0, 1'b0);
      chk("retry_n_clr", w_clr, 3);
      chk("retry_n_evt", w_evt, 1);
      chk("retry_id", int'(w_ids[2:0]), 1);
      chk("retry_clr_err", int'(clr_err), 0);
      chk("retry_busy_drop", w_last_busy, 9);
      blk_limit = 0;

      // Clear always ignored
      coll_reset();
      blk_limit = 1000;
      watch(6'b000001, 20, 1, 0, 6'd0, 1'b1);
      chk("err_n_clr", w_clr, 4);
      chk("err_n_evt", w_evt, 1);
      chk("err_id", int'(w_ids[2:0]), 0);
      chk("err_flag", int'(clr_err), 1);
      chk("err_busy_drop", w_last_busy, 11);
      blk_limit = 0;
      coll_reset();
      chk("err_sticky", int'(clr_err), 1);
      clr_err_ack = 1'b1;
      @(negedge pclk);
      clr_err_ack = 1'b0;
      chk("err_ack", int'(clr_err), 0);

      // New source arriving during dispatch is taken on the next pass
      watch(6'b000001, 20, 7, 5, 6'b001000, 1'b0);
      chk("new_n_evt", w_evt, 2);
      chk("new_id0", int'(w_ids[2:0]), 0);
      chk("new_id1", int'(w_ids[5:3]), 3);
      chk("new_n_clr", w_clr, 2);
      chk("new_busy_drop", w_last_busy, 12);

      // Spurious interrupt: capture then straight back to idle
      spur = 1'b1;
      @(negedge pclk);
      spur = 1'b0;
      chk("spur_capture_busy", int'(busy), 1);
      watch(6'd0, 8, 1, 0, 6'd0, 1'b0);
      chk("spur_n_clr", w_clr, 0);
      chk("spur_n_evt", w_evt, 0);
      chk("spur_busy", w_last_busy, 0);

      // Reset mid-dispatch
      set_mask  = 6'b000110;
      evt_ready = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge pclk);
         set_mask = 6'd0;
      end
      chk("rstd_valid_before", int'(evt_valid), 1);
      p_reset = 1'b1;
      @(negedge pclk);
      p_reset = 1'b0;
      chk("rstd_valid", int'(evt_valid), 0);
      chk("rstd_busy", int'(busy), 0);
      watch(6'd0, 10, 1, 0, 6'd0, 1'b0);
      chk("rstd_n_evt", w_evt, 0);
      chk("rstd_n_clr", w_clr, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
